// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative mul/div datapath: LOAD -> RUN (ITERATIONS steps) -> DONE, with the ready pulse ITERATIONS+2 cycles after start.
// No backpressure; a new start in any state restarts the operation. `MULTDIV_RDY_HOLD_EN holds DONE until the next start.
module multdiv_ctrl #(
  parameter int ITERATIONS = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ctrl_MULT,
  input  logic       ctrl_DIV,
  input  logic [5:0] count,
  input  logic       divisor_zero,
  input  logic       mult_ovf,
  output logic       cnt_clr,
  output logic       cnt_en,
  output logic       load,
  output logic       step,
  output logic       op_is_div,
  output logic       busy,
  output logic       data_resultRDY,
  output logic       data_exception
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

  state_t state, state_nxt;
  logic   exc, exc_nxt;
  logic   op_nxt;
  logic   start;
  logic   last_iter;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (count == LAST_COUNT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      exc       <= 1'b0;
      op_is_div <= 1'b0;
      cnt_clr   <= 1'b0;
    end else begin
      state     <= state_nxt;
      exc       <= exc_nxt;
      op_is_div <= op_nxt;
      // Registered so the counter's async clear input never sees a decode glitch.
      cnt_clr   <= (state_nxt == LOAD);
    end
  end

  always_comb begin
    state_nxt = state;
    exc_nxt   = exc;
    op_nxt    = op_is_div;
    if (start) begin
      // A start in any state aborts the current operation; multiply has priority.
      state_nxt = LOAD;
      op_nxt    = ~ctrl_MULT;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        LOAD: begin
          if (op_is_div && divisor_zero) begin
            exc_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            exc_nxt   = 1'b0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (last_iter) begin
            state_nxt = DONE;
            if (!op_is_div) exc_nxt = mult_ovf;
          end
        end
        DONE: begin
`ifdef MULTDIV_RDY_HOLD_EN
          state_nxt = DONE;
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    load           = (state == LOAD);
    step           = (state == RUN);
    cnt_en         = (state == RUN);
    busy           = (state == LOAD) || (state == RUN);
    data_resultRDY = (state == DONE);
    data_exception = (state == DONE) && exc;
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: a 6-bit counter model closes the loop; expectations come from an op timeline (cycles since start).
module tb_multdiv_ctrl;
  localparam int ITER = 32;
`ifdef MULTDIV_RDY_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic       divisor_zero = 1'b0, mult_ovf = 1'b0;
  logic [5:0] count = '0;
  logic       cnt_clr, cnt_en, load, step, op_is_div, busy, data_resultRDY, data_exception;
  logic       cnt_rst;

  int checks = 0;
  int errors = 0;

  // Timeline model: mt = 0 idle, 1 = load cycle, 2.. = cycles into the operation.
  int mt    = 0;
  bit mdiv  = 1'b0;
  bit mexc  = 1'b0;
  bit mshort = 1'b0;

  multdiv_ctrl #(.ITERATIONS(ITER)) dut (
    .clk(clk), .clr(clr), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .count(count),
    .divisor_zero(divisor_zero), .mult_ovf(mult_ovf), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
    .load(load), .step(step), .op_is_div(op_is_div), .busy(busy),
    .data_resultRDY(data_resultRDY), .data_exception(data_exception)
  );

  always #5 clk = ~clk;

  assign cnt_rst = clr | cnt_clr;
  always @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst) count <= '0;
    else if (cnt_en) count <= count + 6'd1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit m, input bit d, input bit dz, input bit ovf);
    int last;
    if (m || d) begin
      mt = 1; mdiv = !m; mshort = 1'b0;
    end else if (mt == 1) begin
      mshort = mdiv && dz;
      mexc   = mshort;
      mt     = 2;
    end else if (mt != 0) begin
      last = mshort ? 2 : ITER + 2;
      if (mt == last) mt = HOLD ? last : 0;
      else begin
        if (mt == ITER + 1 && !mdiv) mexc = ovf;
        mt++;
      end
    end
  endtask

  task automatic check_all();
    int last;
    bit e_run, e_rdy;
    last  = mshort ? 2 : ITER + 2;
    e_run = !mshort && mt >= 2 && mt <= ITER + 1;
    e_rdy = (mt != 0) && (mt == last);
    chk("load", int'(load), int'(mt == 1));
    chk("cnt_clr", int'(cnt_clr), int'(mt == 1));
    chk("step", int'(step), int'(e_run));
    chk("cnt_en", int'(cnt_en), int'(e_run));
    chk("busy", int'(busy), int'(mt == 1 || e_run));
    chk("rdy", int'(data_resultRDY), int'(e_rdy));
    chk("exc", int'(data_exception), int'(e_rdy && mexc));
    chk("op_is_div", int'(op_is_div), int'(mdiv));
  endtask

  task automatic tick(input bit m, input bit d, input bit dz, input bit ovf);
    ctrl_MULT = m; ctrl_DIV = d; divisor_zero = dz; mult_ovf = ovf;
    @(posedge clk);
    model_edge(m, d, dz, ovf);
    #1;
    check_all();
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
  endtask

  task automatic do_reset();
    #2 clr = 1'b1;
    #1;
    mt = 0; mdiv = 1'b0; mexc = 1'b0; mshort = 1'b0;
    check_all();
    #2 clr = 1'b0;
  endtask

  // Runs one operation from its start tick and returns the tick index at which RDY was first seen.
  task automatic run_op(input bit m, input bit d, input bit dz, input bit ovf, input int n,
                        output int rdy_at, output int step_cnt);
    rdy_at = -1; step_cnt = 0;
    for (int i = 1; i <= n; i++) begin
      tick((i == 1) ? m : 1'b0, (i == 1) ? d : 1'b0, dz, ovf);
      if (step) step_cnt++;
      if (data_resultRDY && rdy_at < 0) rdy_at = i;
    end
  endtask

  initial begin
    int rdy_at, steps, rdy_cnt;
    bit rm, rd;

    @(negedge clk);
    do_reset();

    // Multiply without overflow: RDY at tick ITER+2, ITER steps.
    run_op(1, 0, 0, 0, ITER + 8, rdy_at, steps);
    chk("mul_rdy_cycle", rdy_at, ITER + 2);
    chk("mul_steps", steps, ITER);

    // Multiply with overflow.
    do_reset();
    run_op(1, 0, 0, 1, ITER + 8, rdy_at, steps);
    chk("ovf_rdy_cycle", rdy_at, ITER + 2);

    // Divide by zero: RDY at tick 2, no steps.
    do_reset();
    run_op(0, 1, 1, 0, 12, rdy_at, steps);
    chk("dz_rdy_cycle", rdy_at, 2);
    chk("dz_steps", steps, 0);

    // Divide, divisor nonzero (overflow flag must be ignored).
    do_reset();
    run_op(0, 1, 0, 1, ITER + 6, rdy_at, steps);
    chk("div_rdy_cycle", rdy_at, ITER + 2);

    // Restart: divide, then multiply when count is 10.
    do_reset();
    rdy_cnt = 0;
    tick(0, 1, 0, 0);
    for (int i = 0; i < 11; i++) begin
      tick(0, 0, 0, 0);
      if (data_resultRDY) rdy_cnt++;
    end
    chk("restart_count", int'(count), 10);
    run_op(1, 0, 0, 0, ITER + 4, rdy_at, steps);
    chk("restart_rdy_cycle", rdy_at, ITER + 2);
    chk("aborted_rdy", rdy_cnt, 0);

    // Both starts together: multiply wins.
    do_reset();
    run_op(1, 1, 1, 0, ITER + 14, rdy_at, steps);
    chk("both_rdy_cycle", rdy_at, ITER + 2);

    // Async clear mid-RUN at count 20.
    do_reset();
    tick(0, 1, 0, 0);
    for (int i = 0; i < 21; i++) tick(0, 0, 0, 0);
    chk("pre_clr_count", int'(count), 20);
    do_reset();
    chk("post_clr_count", int'(count), 0);

    // Randomized traffic with sparse, sometimes overlapping start pulses.
    for (int i = 0; i < 2500; i++) begin
      rm = 1'b0; rd = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        rm = 1'($urandom_range(0, 1));
        rd = rm ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick(rm, rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Sequencer FSM for the iterative multiply/divide unit. It sits directly downstream of the 6-bit cycle counter and consumes that counter's count. It drives the counter's clear and enable, and sequences the datapath through load, iterate and finish. It reports completion and exceptions to the processor with a ready pulse.

Parameters:
ITERATIONS, 32, number of datapath step cycles per operation; legal range 1..63 (limited by the 6-bit count)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-high reset
ctrl_MULT  in  1  start-multiply pulse, sampled on clk
ctrl_DIV  in  1  start-divide pulse, sampled on clk
count  in  6  current value from the downstream-of-counter cycle counter
divisor_zero  in  1  datapath flag: loaded divisor == 0, valid in LOAD
mult_ovf  in  1  datapath overflow flag, valid in the last RUN cycle
cnt_clr  out  1  counter clear, registered
cnt_en  out  1  counter enable
load  out  1  datapath load operands
step  out  1  datapath perform one iteration
op_is_div  out  1  latched operation, 1 = divide
busy  out  1  operation in progress (LOAD or RUN)
data_resultRDY  out  1  result valid
data_exception  out  1  exception qualifier, valid with data_resultRDY

Behaviour:
- States: IDLE, LOAD, RUN, DONE. On clr: state = IDLE, op_is_div = 0, exc latch = 0, and all outputs = 0. clr is asynchronous and overrides everything, including mid-operation.
- Outputs:
  - cnt_clr is a flop, so the async counter clear never glitches.
  - All other outputs are decoded from the state register and latches only; none depend on inputs.
- IDLE: all outputs 0.
  - ctrl_MULT or ctrl_DIV high at an edge → LOAD. op_is_div latched at that edge.
  - Both high together: ctrl_MULT wins, op_is_div = 0.
- LOAD (1 cycle): load = 1, busy = 1, cnt_clr = 1. Counter reads 0 on entry to RUN.
  - op_is_div = 1 and divisor_zero = 1: latch exc = 1, go to DONE, skip RUN.
  - Otherwise: exc = 0, go to RUN.
- RUN: step = 1, cnt_en = 1, busy = 1.
  - count == ITERATIONS-1 at an edge → DONE. That cycle's step is the final one.
  - In that same cycle, if op_is_div = 0, latch exc = mult_ovf.
- DONE (1 cycle): data_resultRDY = 1, data_exception = exc. Next state IDLE.
- Latency: start sampled at edge 0 → LOAD in cycle 1 → RUN in cycles 2..ITERATIONS+1 → DONE in cycle ITERATIONS+2. Default: RDY in cycle 34.
- Divide by zero: RDY in cycle 2 with data_exception = 1.
- Restart: a start pulse in LOAD, RUN or DONE aborts the current operation.
  - Next state is LOAD with the new op; any pending RDY is suppressed.
  - ctrl_MULT priority still applies.
- count is 6 bits; a counter wrap past 63 never occurs because ITERATIONS ≤ 63.
- count is ignored outside RUN.

Optional Feature:
MULTDIV_RDY_HOLD_EN
- Defined: DONE is held, not single-cycle.
  - data_resultRDY and data_exception stay high until the next start pulse, which moves the FSM to LOAD, or until clr.
  - busy = 0 while held.
- Undefined: DONE lasts exactly one cycle and returns to IDLE, so RDY is a single-cycle pulse.

Test Plan:
- Multiply, no overflow: clr pulse, then ctrl_MULT at edge 0 with mult_ovf = 0 → load high in cycle 1 only; step high in cycles 2..33; data_resultRDY = 1 in cycle 34 only with data_exception = 0; op_is_div = 0.
- Multiply overflow: as above with mult_ovf = 1 in the final RUN cycle → data_exception = 1 in cycle 34.
- Divide by zero: ctrl_DIV with divisor_zero = 1 → LOAD in cycle 1; RDY = 1 and exception = 1 in cycle 2; step never asserted.
- Restart: ctrl_DIV, then ctrl_MULT when count = 10 → LOAD next cycle with op_is_div = 0; RDY exactly ITERATIONS+2 cycles after the second pulse; no RDY for the aborted divide.
- Async reset mid-RUN (count = 20): assert clr between edges → busy, step, cnt_en and RDY drop to 0 immediately, without waiting for an edge.
- Simultaneous ctrl_MULT = ctrl_DIV = 1 → op_is_div = 0. With ITERATIONS = 4 overridden: RDY in cycle 6. With MULTDIV_RDY_HOLD_EN: RDY stays high for 10+ idle cycles until the next start pulse.
